mac_result_fifo: RTL and testbench

Downstream buffering stage for the signed 28-bit multiply-accumulate unit. It captures every accumulator value the MAC presents with its output-valid strobe and queues it in a small FIFO. Results are released to the consumer over a valid/ready handshake and tagged when the value sits at a saturation rail. The MAC has no backpressure, so a push to a full FIFO that cannot be absorbed is dropped and counted, never stalled.

---
 rtl/mac_result_fifo.sv | 112 +++++++++++
 tb/tb_mac_result_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
// Result queue behind the signed MAC: show-ahead FIFO with saturation tagging
// and drop accounting for pushes that arrive while the queue is full.
module mac_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28,
    parameter int DROPW = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clear,
    output logic [DROPW-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // A value is tagged only when it sits exactly on one of the two rails.
    function automatic logic sat_tag(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] max_v;
        logic [WIDTH-1:0] min_v;
        max_v = {1'b0, {(WIDTH-1){1'b1}}};
        min_v = {1'b1, {(WIDTH-1){1'b0}}};
        return (d == max_v) || (d == min_v);
    endfunction

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [DROPW-1:0]  r_drop_count;

    logic              w_pop;
    logic              w_push;
    logic              w_reject;
    logic              w_drop_full;
    logic [WIDTH:0]    w_head;

    assign w_pop       = (r_count != {CW{1'b0}}) & out_ready;
    // Full pass-through: a pop in the same cycle frees the slot being written.
    assign w_push      = in_valid & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_reject    = in_valid & ~w_push;
    assign w_drop_full = &r_drop_count;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage array; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= {sat_tag(in_data), in_data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= {DROPW{1'b0}};
        end else if (w_reject) begin
            r_overflow <= 1'b1;
            if (ovf_clear) begin
                r_drop_count <= DROPW'(1);
            end else if (!w_drop_full) begin
                r_drop_count <= r_drop_count + DROPW'(1);
            end else begin
                r_drop_count <= r_drop_count;
            end
        end else if (ovf_clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= {DROPW{1'b0}};
        end else begin
            r_overflow   <= r_overflow;
            r_drop_count <= r_drop_count;
        end
    end

    assign out_data   = w_head[WIDTH-1:0];
    assign out_sat    = w_head[WIDTH];
    assign out_valid  = (r_count != {CW{1'b0}});
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Directed self-checking bench for mac_result_fifo (DEPTH=4, WIDTH=28, DROPW=8).
module tb_mac_result_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [27:0] in_data;
    logic        in_valid;
    logic [27:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow;
    logic        ovf_clear;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    mac_result_fifo #(.DEPTH(4), .WIDTH(28), .DROPW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic v, input logic [2:0] c,
                                input logic o, input logic [7:0] d);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".count"}, {29'd0, count}, {29'd0, c});
        check({tag, ".ovf"},   {31'd0, overflow}, {31'd0, o});
        check({tag, ".drop"},  {24'd0, drop_count}, {24'd0, d});
    endtask

    task automatic check_head(input string tag, input logic [27:0] d, input logic s);
        check({tag, ".data"}, {4'd0, out_data}, {4'd0, d});
        check({tag, ".sat"},  {31'd0, out_sat}, {31'd0, s});
    endtask

    initial begin
        reset     = 1'b0;
        in_data   = 28'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clear = 1'b0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b1;
        check_status("reset", 1'b0, 3'd0, 1'b0, 8'd0);
        tick();
        check_status("idle", 1'b0, 3'd0, 1'b0, 8'd0);

        // Ordered flow
        in_valid = 1'b1; in_data = 28'd5;
        tick();
        check_status("flow.p1", 1'b1, 3'd1, 1'b0, 8'd0);
        check_head("flow.p1", 28'd5, 1'b0);
        in_data = 28'hFFFFFFD;
        tick();
        check("flow.p2.count", {29'd0, count}, 32'd2);
        in_data = 28'd1000;
        tick();
        check("flow.p3.count", {29'd0, count}, 32'd3);
        check_head("flow.h0", 28'd5, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("flow.q1.count", {29'd0, count}, 32'd2);
        check_head("flow.h1", 28'hFFFFFFD, 1'b0);
        tick();
        check("flow.q2.count", {29'd0, count}, 32'd1);
        check_head("flow.h2", 28'd1000, 1'b0);
        tick();
        check_status("flow.empty", 1'b0, 3'd0, 1'b0, 8'd0);
        out_ready = 1'b0;

        // Saturation tag
        in_valid = 1'b1; in_data = 28'h7FFFFFF;
        tick();
        in_data = 28'h8000000;
        tick();
        in_data = 28'h7FFFFFE;
        tick();
        in_valid = 1'b0;
        check_head("sat.max", 28'h7FFFFFF, 1'b1);
        out_ready = 1'b1;
        tick();
        check_head("sat.min", 28'h8000000, 1'b1);
        tick();
        check_head("sat.near", 28'h7FFFFFE, 1'b0);
        tick();
        check("sat.empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Overflow: six pushes into a four-deep queue
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 28'(10 + i);
            tick();
        end
        check_status("ovf.full", 1'b1, 3'd4, 1'b0, 8'd0);
        in_data = 28'd14;
        tick();
        check_status("ovf.d1", 1'b1, 3'd4, 1'b1, 8'd1);
        in_data = 28'd15;
        tick();
        in_valid = 1'b0;
        check_status("ovf.d2", 1'b1, 3'd4, 1'b1, 8'd2);
        check_head("ovf.keep", 28'd10, 1'b0);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check_status("ovf.clear", 1'b1, 3'd4, 1'b0, 8'd0);

        // Full pass-through: simultaneous push and pop while full
        in_valid = 1'b1; in_data = 28'd77; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_status("pass", 1'b1, 3'd4, 1'b0, 8'd0);
        check_head("pass.h11", 28'd11, 1'b0);
        tick();
        check_head("pass.h12", 28'd12, 1'b0);
        tick();
        check_head("pass.h13", 28'd13, 1'b0);
        tick();
        check_head("pass.h77", 28'd77, 1'b0);
        check("pass.count1", {29'd0, count}, 32'd1);
        tick();
        check("pass.empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Drop beats clear in the same cycle
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 28'(20 + i);
            tick();
        end
        in_data = 28'd24; ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check_status("setwins", 1'b1, 3'd4, 1'b1, 8'd1);

        // Drop counter saturates at all-ones
        for (int i = 0; i < 260; i++) begin
            tick();
        end
        in_valid = 1'b0;
        check_status("dropsat", 1'b1, 3'd4, 1'b1, 8'hFF);
        check_head("dropsat.keep", 28'd20, 1'b0);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check_status("dropsat.clear", 1'b1, 3'd4, 1'b0, 8'd0);

        // Reset mid-burst with a push in the reset cycle
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mid.count3", {29'd0, count}, 32'd3);
        reset = 1'b0; in_valid = 1'b1; in_data = 28'd99;
        tick();
        check_status("mid.reset", 1'b0, 3'd0, 1'b0, 8'd0);
        reset = 1'b1; in_data = 28'd55;
        tick();
        in_valid = 1'b0;
        check_status("mid.push", 1'b1, 3'd1, 1'b0, 8'd0);
        check_head("mid.head", 28'd55, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_status("mid.empty", 1'b0, 3'd0, 1'b0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
